// File: rtl/morph_seq_ctrl_if.sv
// morph_seq_ctrl_if: video timing, configuration handshake and status bundle for
// the morphology sequencer.
//   pre_frame_vsync/hsync/clken : incoming video timing (frame, line, pixel valid)
//   cfg_valid/cfg_ready         : config offer and acceptance
//   cfg_seq/cfg_len/cfg_loop    : op list (2 bits per op), op count, repeat flag
//   err_clr                     : clears the sticky geometry errors
//   morph_sel                   : op applied to the current frame
//   frame_start/seq_done        : single-cycle event pulses
//   busy/frame_cnt              : sequencer activity and frames run under config
//   err_line/err_frame          : sticky geometry errors
// master drives video/config (source side), slave is the controller.
interface morph_seq_ctrl_if #(
    parameter int unsigned SEQ_LEN = 4
);
    logic                   pre_frame_vsync;
    logic                   pre_frame_hsync;
    logic                   pre_frame_clken;
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [2*SEQ_LEN-1:0]   cfg_seq;
    logic [2:0]             cfg_len;
    logic                   cfg_loop;
    logic                   err_clr;
    logic [1:0]             morph_sel;
    logic                   frame_start;
    logic                   seq_done;
    logic                   busy;
    logic [15:0]            frame_cnt;
    logic                   err_line;
    logic                   err_frame;

    modport master (
        output pre_frame_vsync, pre_frame_hsync, pre_frame_clken,
        output cfg_valid, cfg_seq, cfg_len, cfg_loop, err_clr,
        input  cfg_ready, morph_sel, frame_start, seq_done, busy, frame_cnt,
        input  err_line, err_frame
    );

    modport slave (
        input  pre_frame_vsync, pre_frame_hsync, pre_frame_clken,
        input  cfg_valid, cfg_seq, cfg_len, cfg_loop, err_clr,
        output cfg_ready, morph_sel, frame_start, seq_done, busy, frame_cnt,
        output err_line, err_frame
    );
endinterface

// File: rtl/morph_seq_ctrl.sv
// morph_seq_ctrl: frame-level scheduler for the 3x3 binary morphology stage.
// Picks erode/dilate/bypass per frame from a programmed op sequence, changing
// the op only on vsync rising, and checks incoming frame geometry.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : morph_seq_ctrl_if.slave (video timing in, config handshake, status out)
module morph_seq_ctrl #(
    parameter int unsigned IMG_W   = 640,
    parameter int unsigned IMG_H   = 480,
    parameter int unsigned SEQ_LEN = 4,
    parameter int unsigned CNT_W   = 12
) (
    input logic            clk,
    input logic            rst,
    morph_seq_ctrl_if.slave bus
);
    localparam int unsigned      IdxW   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam logic [2:0]       MaxLen = 3'(SEQ_LEN);
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] ImgW   = CNT_W'(IMG_W);
    localparam logic [CNT_W-1:0] ImgH   = CNT_W'(IMG_H);

    typedef enum logic [1:0] {StIdle, StArmed, StRun} state_t;

    state_t               state_q, state_d;
    logic [2*SEQ_LEN-1:0] seq_q, seq_d;
    logic [2:0]           len_q, len_d;
    logic                 loop_q, loop_d;
    logic [2:0]           idx_q, idx_d;
    logic [1:0]           morph_sel_q, morph_sel_d;
    logic                 frame_start_q, frame_start_d;
    logic                 seq_done_q, seq_done_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic                 err_line_q, err_line_d;
    logic                 err_frame_q, err_frame_d;
    logic [CNT_W-1:0]     pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0]     line_cnt_q, line_cnt_d;
    logic                 vs_d, hs_d;

    logic                 vs_rise, vs_fall, hs_fall;
    logic                 cfg_ready, cfg_fire;
    logic [2:0]           len_clamped;
    logic [1:0]           ops [SEQ_LEN];
    logic [1:0]           cur_op;

    assign vs_rise = bus.pre_frame_vsync & ~vs_d;
    assign vs_fall = ~bus.pre_frame_vsync & vs_d;
    assign hs_fall = ~bus.pre_frame_hsync & hs_d;

    // Refusing config while vsync is high keeps a handshake from racing a frame start.
    assign cfg_ready = (state_q != StRun) & ~bus.pre_frame_vsync;
    assign cfg_fire  = bus.cfg_valid & cfg_ready;

    always_comb begin
        len_clamped = bus.cfg_len;
        if (bus.cfg_len == 3'd0) begin
            len_clamped = 3'd1;
        end else if (bus.cfg_len > MaxLen) begin
            len_clamped = MaxLen;
        end
    end

    always_comb begin
        for (int k = 0; k < int'(SEQ_LEN); k++) begin
            ops[k] = seq_q[2*k +: 2];
        end
        cur_op = ops[idx_q[IdxW-1:0]];
        // Reserved code 11 runs as bypass.
        if (cur_op == 2'b11) begin
            cur_op = 2'b00;
        end
    end

    // Sequencer
    always_comb begin
        state_d       = state_q;
        seq_d         = seq_q;
        len_d         = len_q;
        loop_d        = loop_q;
        idx_d         = idx_q;
        morph_sel_d   = morph_sel_q;
        frame_start_d = 1'b0;
        seq_done_d    = 1'b0;
        frame_cnt_d   = frame_cnt_q;

        if (cfg_fire) begin
            seq_d       = bus.cfg_seq;
            len_d       = len_clamped;
            loop_d      = bus.cfg_loop;
            idx_d       = 3'd0;
            frame_cnt_d = 16'd0;
            state_d     = StArmed;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (vs_rise) begin
                        morph_sel_d   = 2'b00;
                        frame_start_d = 1'b1;
                    end
                end
                StArmed: begin
                    if (vs_rise) begin
                        morph_sel_d   = cur_op;
                        frame_start_d = 1'b1;
                        state_d       = StRun;
                    end
                end
                StRun: begin
                    if (vs_fall) begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        if (idx_q == len_q - 3'd1) begin
                            idx_d = 3'd0;
                            if (loop_q) begin
                                state_d = StArmed;
                            end else begin
                                state_d     = StIdle;
                                seq_done_d  = 1'b1;
                                morph_sel_d = 2'b00;
                            end
                        end else begin
                            idx_d   = idx_q + 3'd1;
                            state_d = StArmed;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Geometry monitor; a set event outranks err_clr in the same cycle.
    always_comb begin
        pix_cnt_d   = pix_cnt_q;
        line_cnt_d  = line_cnt_q;
        err_line_d  = err_line_q;
        err_frame_d = err_frame_q;

        if (hs_fall) begin
            pix_cnt_d = '0;
        end else if (bus.pre_frame_clken && bus.pre_frame_hsync && pix_cnt_q != CntMax) begin
            pix_cnt_d = pix_cnt_q + 1'b1;
        end

        if (vs_rise) begin
            line_cnt_d = '0;
        end else if (hs_fall && bus.pre_frame_vsync && line_cnt_q != CntMax) begin
            line_cnt_d = line_cnt_q + 1'b1;
        end

        if (bus.err_clr) begin
            err_line_d  = 1'b0;
            err_frame_d = 1'b0;
        end
        if (hs_fall && pix_cnt_q != ImgW) begin
            err_line_d = 1'b1;
        end
        if (vs_fall && line_cnt_q != ImgH) begin
            err_frame_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            seq_q         <= '0;
            len_q         <= 3'd0;
            loop_q        <= 1'b0;
            idx_q         <= 3'd0;
            morph_sel_q   <= 2'b00;
            frame_start_q <= 1'b0;
            seq_done_q    <= 1'b0;
            frame_cnt_q   <= 16'd0;
            err_line_q    <= 1'b0;
            err_frame_q   <= 1'b0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            vs_d          <= 1'b0;
            hs_d          <= 1'b0;
        end else begin
            state_q       <= state_d;
            seq_q         <= seq_d;
            len_q         <= len_d;
            loop_q        <= loop_d;
            idx_q         <= idx_d;
            morph_sel_q   <= morph_sel_d;
            frame_start_q <= frame_start_d;
            seq_done_q    <= seq_done_d;
            frame_cnt_q   <= frame_cnt_d;
            err_line_q    <= err_line_d;
            err_frame_q   <= err_frame_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            vs_d          <= bus.pre_frame_vsync;
            hs_d          <= bus.pre_frame_hsync;
        end
    end

    assign bus.cfg_ready   = cfg_ready;
    assign bus.morph_sel   = morph_sel_q;
    assign bus.frame_start = frame_start_q;
    assign bus.seq_done    = seq_done_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.err_line    = err_line_q;
    assign bus.err_frame   = err_frame_q;
endmodule

// File: tb/tb_morph_seq_ctrl.sv
// tb_morph_seq_ctrl: directed and randomized frames for morph_seq_ctrl with a
// queue-based reference model of the op schedule and geometry errors.
module tb_morph_seq_ctrl;
    localparam int unsigned IMG_W   = 8;
    localparam int unsigned IMG_H   = 4;
    localparam int unsigned SEQ_LEN = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errs   = 0;

    // Reference model: pending ops in play order; looping re-queues the op just run.
    logic [1:0] op_q [$];
    bit         loop_m    = 0;
    int         fcnt_m    = 0;
    bit         eline_m   = 0;
    bit         eframe_m  = 0;

    morph_seq_ctrl_if #(.SEQ_LEN(SEQ_LEN)) bus ();

    morph_seq_ctrl #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .SEQ_LEN(SEQ_LEN),
        .CNT_W  (12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] play_op(input logic [1:0] op);
        return (op == 2'b11) ? 2'b00 : op;
    endfunction

    task automatic do_line(input int npix);
        for (int p = 0; p < npix; p++) begin
            @(posedge clk) #1;
            bus.pre_frame_hsync = 1'b1;
            bus.pre_frame_clken = 1'b1;
        end
        @(posedge clk) #1;
        bus.pre_frame_hsync = 1'b0;
        bus.pre_frame_clken = 1'b0;
        @(posedge clk) #1;
        @(posedge clk) #1;
    endtask

    task automatic apply_cfg(input logic [7:0] seq, input logic [2:0] len, input bit loop);
        bit ok = 0;
        int eff;
        @(posedge clk) #1;
        bus.cfg_seq   = seq;
        bus.cfg_len   = len;
        bus.cfg_loop  = loop;
        bus.cfg_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.cfg_ready === 1'b1) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk) #1;
        bus.cfg_valid = 1'b0;
        check("cfg_handshake", 32'(ok), 32'd1);
        eff = (len == 0) ? 1 : ((len > 3'(SEQ_LEN)) ? int'(SEQ_LEN) : int'(len));
        op_q.delete();
        for (int k = 0; k < eff; k++) op_q.push_back(seq[2*k +: 2]);
        loop_m = loop;
        fcnt_m = 0;
        @(negedge clk);
        check("cfg_busy", 32'(bus.busy), 32'd1);
        check("cfg_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    endtask

    task automatic run_frame(input int nlines, input int bad_line, input bit start_cfg);
        logic [1:0] esel;
        logic [1:0] op;
        bit         edone = 0;
        bit         ebusy;
        esel  = (op_q.size() > 0) ? play_op(op_q[0]) : 2'b00;
        ebusy = (op_q.size() > 0);
        @(posedge clk) #1;
        bus.pre_frame_vsync = 1'b1;
        if (start_cfg) bus.cfg_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("frame_start_pulse", 32'(bus.frame_start), 32'd1);
        check("morph_sel_start", 32'(bus.morph_sel), 32'(esel));
        check("busy_in_frame", 32'(bus.busy), 32'(ebusy));
        @(posedge clk);
        @(negedge clk);
        check("frame_start_low", 32'(bus.frame_start), 32'd0);
        for (int l = 0; l < nlines; l++) begin
            do_line((l == bad_line) ? int'(IMG_W) - 1 : int'(IMG_W));
            check("cfg_ready_in_frame", 32'(bus.cfg_ready), 32'd0);
            check("morph_sel_hold", 32'(bus.morph_sel), 32'(esel));
        end
        if (bad_line >= 0 && bad_line < nlines) eline_m = 1;
        if (nlines != int'(IMG_H)) eframe_m = 1;
        @(posedge clk) #1;
        bus.pre_frame_vsync = 1'b0;
        if (op_q.size() > 0) begin
            op = op_q.pop_front();
            fcnt_m = (fcnt_m + 1) % 65536;
            if (loop_m) op_q.push_back(op);
            edone = !loop_m && op_q.size() == 0;
            if (edone) esel = 2'b00;
        end
        @(posedge clk);
        @(negedge clk);
        check("seq_done_at_end", 32'(bus.seq_done), 32'(edone));
        check("frame_cnt", 32'(bus.frame_cnt), 32'(fcnt_m));
        check("err_line", 32'(bus.err_line), 32'(eline_m));
        check("err_frame", 32'(bus.err_frame), 32'(eframe_m));
        check("busy_after_frame", 32'(bus.busy), 32'(op_q.size() > 0));
        check("morph_sel_blank", 32'(bus.morph_sel), 32'(esel));
        @(posedge clk);
        @(negedge clk);
        check("seq_done_low", 32'(bus.seq_done), 32'd0);
        @(posedge clk) #1;
        @(posedge clk) #1;
    endtask

    task automatic pulse_err_clr();
        @(posedge clk) #1;
        bus.err_clr = 1'b1;
        @(posedge clk) #1;
        bus.err_clr = 1'b0;
        eline_m  = 0;
        eframe_m = 0;
        @(negedge clk);
        check("err_line_clr", 32'(bus.err_line), 32'd0);
        check("err_frame_clr", 32'(bus.err_frame), 32'd0);
    endtask

    initial begin
        logic [7:0] rseq;
        logic [2:0] rlen;
        bit         rloop;
        int         nfr, nl, bl;

        rst = 1'b1;
        bus.pre_frame_vsync = 1'b0;
        bus.pre_frame_hsync = 1'b0;
        bus.pre_frame_clken = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_seq   = '0;
        bus.cfg_len   = '0;
        bus.cfg_loop  = 1'b0;
        bus.err_clr   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_morph_sel", 32'(bus.morph_sel), 32'd0);
        check("rst_frame_start", 32'(bus.frame_start), 32'd0);
        check("rst_seq_done", 32'(bus.seq_done), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        check("rst_err_line", 32'(bus.err_line), 32'd0);
        check("rst_err_frame", 32'(bus.err_frame), 32'd0);
        @(posedge clk) #1;
        rst = 1'b0;

        // No config: bypass frames.
        run_frame(IMG_H, -1, 0);
        run_frame(IMG_H, -1, 0);

        // Erode then dilate, run once; third frame falls back to bypass.
        apply_cfg(8'b00_00_10_01, 3'd2, 1'b0);
        repeat (3) run_frame(IMG_H, -1, 0);

        // Same sequence looping.
        apply_cfg(8'b00_00_10_01, 3'd2, 1'b1);
        repeat (5) run_frame(IMG_H, -1, 0);

        // Config offered at frame start is held off until blanking.
        bus.cfg_seq  = 8'b00_00_01_10;
        bus.cfg_len  = 3'd2;
        bus.cfg_loop = 1'b0;
        run_frame(IMG_H, -1, 1);
        apply_cfg(8'b00_00_01_10, 3'd2, 1'b0);
        run_frame(IMG_H, -1, 0);

        // Short line and short frame; sequence still advances.
        run_frame(3, 1, 0);
        pulse_err_clr();

        // Reset in the middle of the second frame of a looping sequence.
        apply_cfg(8'b00_01_10_01, 3'd3, 1'b1);
        run_frame(IMG_H, -1, 0);
        @(posedge clk) #1;
        bus.pre_frame_vsync = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_morph_sel", 32'(bus.morph_sel), 32'd2);
        do_line(IMG_W);
        do_line(IMG_W);
        rst = 1'b1;
        #1;
        check("mid_rst_morph_sel", 32'(bus.morph_sel), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        check("mid_rst_frame_start", 32'(bus.frame_start), 32'd0);
        bus.pre_frame_vsync = 1'b0;
        @(posedge clk) #1;
        rst = 1'b0;
        op_q.delete();
        loop_m = 0;
        fcnt_m = 0;
        eline_m = 0;
        eframe_m = 0;
        run_frame(IMG_H, -1, 0);

        // Randomized configs and geometry.
        for (int r = 0; r < 8; r++) begin
            rseq  = 8'($urandom);
            rlen  = 3'($urandom_range(0, 7));
            rloop = 1'($urandom_range(0, 1));
            apply_cfg(rseq, rlen, rloop);
            nfr = $urandom_range(1, 6);
            for (int f = 0; f < nfr; f++) begin
                nl = ($urandom_range(0, 4) == 0) ? int'(IMG_H) - 1 : int'(IMG_H);
                bl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
                run_frame(nl, bl, 0);
            end
            if (r % 2 == 1) pulse_err_clr();
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule

// File: doc/morph_seq_ctrl.md
Name: morph_seq_ctrl

Overview:
- Frame-level scheduler for the binary morphology stage behind the Sobel/binarisation path.
- Selects per frame whether the 3x3 stage performs erosion, dilation or bypass, following a programmed op sequence. Open = erode then dilate; close = dilate then erode.
- Op changes only at frame boundaries. The block also monitors frame geometry and flags malformed frames.

Parameters:
- IMG_W, 640, expected clken pixels per hsync-active line.
- IMG_H, 480, expected lines per vsync-active frame.
- SEQ_LEN, 4, maximum ops in a sequence (2 bits per op).
- CNT_W, 12, width of the pixel and line counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- pre_frame_vsync  in  1  frame valid, high during a frame.
- pre_frame_hsync  in  1  line valid.
- pre_frame_clken  in  1  pixel enable.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  config accepted when cfg_valid & cfg_ready.
- cfg_seq  in  2*SEQ_LEN  op list, op k at bits [2k+1:2k]. 00 bypass, 01 erode, 10 dilate, 11 reserved (treated as bypass).
- cfg_len  in  3  ops in sequence; 0 is treated as 1; values above SEQ_LEN are clamped to SEQ_LEN.
- cfg_loop  in  1  1: repeat sequence forever; 0: run once.
- err_clr  in  1  clears sticky error flags.
- morph_sel  out  2  op for the current frame (same encoding as cfg_seq).
- frame_start  out  1  one-cycle pulse, frame begun.
- seq_done  out  1  one-cycle pulse, non-loop sequence finished.
- busy  out  1  state != IDLE.
- frame_cnt  out  16  frames processed under config, wraps at 0xFFFF->0.
- err_line  out  1  sticky, a line length != IMG_W.
- err_frame  out  1  sticky, a frame height != IMG_H.

Behaviour:
- Reset values: all outputs 0; state IDLE; seq_idx 0; counters 0; vs_d/hs_d 0.
- Edge detect:
  - vs_d and hs_d register the inputs.
  - vs_rise = vsync & ~vs_d; vs_fall = ~vsync & vs_d; hs_fall = ~hsync & hs_d.
- States:
  - IDLE: no active config. vs_rise -> morph_sel=00, frame_start=1, stay IDLE.
  - ARMED: config held, waiting for a frame. vs_rise -> morph_sel=seq[seq_idx], frame_start=1, go to RUN.
  - RUN: frame in progress. vs_fall ends the frame:
    - frame_cnt+1.
    - If seq_idx == len-1: with loop, seq_idx=0 and go to ARMED; without loop, go to IDLE, seq_done=1, morph_sel=00.
    - Otherwise seq_idx+1 and go to ARMED.
- Latency: morph_sel and frame_start update on the clock edge where vs_rise is seen, so they are valid 1 cycle after vsync rises. morph_sel holds constant through the frame and the following blanking.
- cfg_ready = (state != RUN) & ~pre_frame_vsync (combinational). A config can therefore never collide with a frame start.
- On handshake: latch seq, clamped len and loop; seq_idx=0; frame_cnt=0; go to ARMED. Accepting in ARMED replaces the pending config and restarts the sequence.
- Geometry checks:
  - Pixel counter counts clken & hsync, saturates at 2^CNT_W-1, and clears on hs_fall.
  - At hs_fall, pix_cnt != IMG_W sets err_line.
  - Line counter increments on hs_fall while vsync=1 and clears on vs_rise.
  - At vs_fall, line_cnt != IMG_H sets err_frame.
  - Checks run in all states.
- err_clr clears both error flags. If a set event and err_clr occur in the same cycle, set wins.
- vsync dropping mid-line counts as vs_fall; the partial line is not counted.
- Geometry errors do not alter sequencing.
- rst asserted mid-frame: immediate return to reset values. The controller resynchronises on the next vs_rise, in IDLE.

Test Plan (IMG_W=8, IMG_H=4, SEQ_LEN=4):
- Reset, then 2 frames with no config -> morph_sel=00 both frames, frame_start pulses twice, busy=0, no errors.
- cfg seq={-,-,10,01}, len=2, loop=0, then 3 frames -> morph_sel: 01 for frame 1, 10 for frame 2. seq_done pulses at frame 2 vs_fall. Frame 3 uses 00. frame_cnt=2.
- Same seq with loop=1, 5 frames -> 01,10,01,10,01; seq_done never pulses; frame_cnt=5.
- cfg_valid held high across a frame -> cfg_ready=0 whenever vsync=1. Handshake completes in blanking; new seq applies from the next frame.
- Frame with one line of 7 pixels and only 3 lines -> err_line=1 and err_frame=1, sequence still advances. err_clr pulse -> both return to 0.
- rst pulsed mid-frame while in RUN with seq_idx=1 -> all outputs 0, state IDLE. The next frame runs with morph_sel=00.
